// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial ripple adder computing a + b + cin with a single full-adder
//   cell and a carry flop, one bit per clock, LSB first.
//
//   A start pulse in IDLE captures the operands and the carry-in. WIDTH SHIFT
//   cycles follow with busy high. The result is then loaded into sum/cout, and
//   done pulses for one cycle. sum/cout hold their value until the next result
//   load, so partial bits are never visible on the outputs.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request, sampled only in IDLE
//   a, b   in   WIDTH  operands, captured on the start edge
//   cin    in   1      carry-in, captured on the start edge
//   busy   out  1      high while in SHIFT
//   done   out  1      one-cycle pulse when sum/cout carry a fresh result
//   sum    out  WIDTH  (a+b+cin) mod 2^WIDTH
//   cout   out  1      bit WIDTH of a+b+cin
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter only has to reach WIDTH-1. WIDTH >= 2 keeps CW >= 1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  psum_q, psum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  // Single full-adder cell working on the current LSBs.
  logic fa_s, fa_c;
  logic last_shift;

  always_comb begin
    fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  assign last_shift = (state_q == S_SHIFT) && (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  // Datapath next values
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          psum_d  = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_c;
        // New sum bits enter at the MSB. After WIDTH shifts the LSB has
        // reached bit 0.
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (last_shift) begin
          // Load the outputs from the shifted value, not from psum_q,
          // because the final bit is still in flight this cycle.
          sum_d  = {fa_s, psum_q[WIDTH-1:1]};
          cout_d = fa_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  // Runs one operation on the 8-bit DUT. The operands are scrambled after the
  // start edge. Returns the result, the edges from start to done, and a
  // timeout flag. On return the DUT is back in IDLE.
  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic [8:0] res, output int lat, output bit to);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    to  = (done !== 1'b1);
    res = {cout, sum};
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_w8: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    n_chk++;
    if ({busy2, done2, cout2, sum2} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_w2: busy=%b done=%b cout=%b sum=%h, want all 0", busy2, done2, cout2, sum2);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Case 1 plus a cycle-by-cycle check that sum/cout hold during SHIFT.
  task automatic test_basic;
    logic [8:0] prev;
    prev = {cout, sum};
    a = 8'h35; b = 8'h1A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0 || {cout, sum} !== prev) begin
        n_fail++;
        $display("FAIL basic_shift[%0d]: busy=%b done=%b res=%h, want busy=1 done=0 res=%h",
                 k, busy, done, {cout, sum}, prev);
      end
      @(negedge clk);
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || {cout, sum} !== 9'h04F) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b res=%h, want done=1 busy=0 res=04f",
               done, busy, {cout, sum});
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== 9'h04F) begin
      n_fail++;
      $display("FAIL basic_after: done=%b busy=%b res=%h, want done=0 busy=0 res=04f",
               done, busy, {cout, sum});
    end
  endtask

  task automatic test_overflow;
    logic [8:0] res; int lat; bit to;
    run_op8(8'hFF, 8'h01, 1'b0, res, lat, to);
    n_chk++;
    if (to || res !== 9'h100 || lat != 8) begin
      n_fail++;
      $display("FAIL ovf_ff_01: res=%h lat=%0d to=%b, want res=100 lat=8", res, lat, to);
    end
    run_op8(8'hFF, 8'hFF, 1'b1, res, lat, to);
    n_chk++;
    if (to || res !== 9'h1FF || lat != 8) begin
      n_fail++;
      $display("FAIL ovf_ff_ff_1: res=%h lat=%0d to=%b, want res=1ff lat=8", res, lat, to);
    end
  endtask

  // start held high: the model expects a capture every 10 edges and a done
  // pulse 8 edges after each capture.
  task automatic test_back_to_back;
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    start = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      if (n % 10 == 0) exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
      @(negedge clk);
      if (n % 10 == 8) begin
        exp = exp_q.pop_front();
        n_chk++;
        if (done !== 1'b1 || {cout, sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b_done@%0d: done=%b res=%h, want done=1 res=%h", n, done, {cout, sum}, exp);
        end
      end else begin
        n_chk++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_nodone@%0d: done=%b, want 0", n, done);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [8:0] res; int lat; bit to; bit saw_done;
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: done/busy activity after abort, want none");
    end
    run_op8(8'h10, 8'h20, 1'b0, res, lat, to);
    n_chk++;
    if (to || res !== 9'h030 || lat != 8) begin
      n_fail++;
      $display("FAIL rst_mid_next: res=%h lat=%0d to=%b, want res=030 lat=8", res, lat, to);
    end
  endtask

  task automatic test_width2;
    logic [2:0] exp; int lat;
    for (int i = 0; i < 32; i++) begin
      a2 = 2'(i); b2 = 2'(i >> 2); cin2 = 1'(i >> 4);
      exp = 3'(a2) + 3'(b2) + 3'(cin2);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      n_chk++;
      if (done2 !== 1'b1 || {cout2, sum2} !== exp || lat != 2) begin
        n_fail++;
        $display("FAIL w2[%0d]: res=%h lat=%0d done=%b, want res=%h lat=2", i, {cout2, sum2}, lat, done2, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [7:0] ra, rb; logic rc; logic [8:0] res, exp; int lat; bit to;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = 9'(ra) + 9'(rb) + 9'(rc);
      run_op8(ra, rb, rc, res, lat, to);
      n_chk++;
      if (to || res !== exp || lat != 8) begin
        n_fail++;
        $display("FAIL rand[%0d]: %h+%h+%b res=%h lat=%0d, want res=%h lat=8", i, ra, rb, rc, res, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_width2;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
